// File: rtl/srff_resp_checker_if.sv
// Signal bundle between an SR flop's observer (master) and the
// response checker (slave).
interface srff_resp_checker_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             clr;
  logic             s;
  logic             r;
  logic             q;
  logic             qbar;
  logic             model_q;
  logic             model_valid;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] chk_cnt;
  logic             illegal_seen;
  logic             fail;

  modport master (
    output en, clr, s, r, q, qbar,
    input  model_q, model_valid, mismatch,
    input  err_cnt, chk_cnt, illegal_seen, fail
  );

  modport slave (
    input  en, clr, s, r, q, qbar,
    output model_q, model_valid, mismatch,
    output err_cnt, chk_cnt, illegal_seen, fail
  );
endinterface

// File: rtl/srff_resp_checker.sv
// Golden-model response checker for an SR flip-flop: tracks s/r,
// compares q/qbar one edge later, counts errors and raises fail.
module srff_resp_checker #(
  parameter int CNT_W        = 8,
  parameter int FAIL_THRESH  = 1,
  parameter int STOP_ON_FAIL = 0,
  parameter int ILLEGAL_POL  = 0
) (
  input logic                clk,
  input logic                rst,
  srff_resp_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] THR = CNT_W'(FAIL_THRESH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic             chk;
  logic             bad;
  logic             fail_nxt;
  logic [CNT_W-1:0] chk_nxt;
  logic [CNT_W-1:0] err_nxt;

  // q is judged against the model as it stood before this edge
  always_comb begin
    chk = (state == RUN) && bus.en;
    bad = (bus.model_valid && (bus.q != bus.model_q))
       || (bus.qbar == bus.q);
    chk_nxt = bus.chk_cnt;
    err_nxt = bus.err_cnt;
    if (chk && (bus.chk_cnt != '1))
      chk_nxt = bus.chk_cnt + ONE;
    if (chk && bad && (bus.err_cnt != '1))
      err_nxt = bus.err_cnt + ONE;
    fail_nxt = bus.fail || (err_nxt >= THR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bus.model_q      <= 1'b0;
      bus.model_valid  <= 1'b1;
      bus.mismatch     <= 1'b0;
      bus.err_cnt      <= '0;
      bus.chk_cnt      <= '0;
      bus.illegal_seen <= 1'b0;
      bus.fail         <= 1'b0;
    end else begin
      // the model tracks regardless of FSM state or clr
      unique case ({bus.s, bus.r})
        2'b01: begin
          bus.model_q     <= 1'b0;
          bus.model_valid <= 1'b1;
        end
        2'b10: begin
          bus.model_q     <= 1'b1;
          bus.model_valid <= 1'b1;
        end
        2'b11: begin
          if (ILLEGAL_POL != 0) begin
            bus.model_q     <= 1'b1;
            bus.model_valid <= 1'b1;
          end else begin
            bus.model_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      if (bus.clr) begin
        state            <= IDLE;
        bus.mismatch     <= 1'b0;
        bus.err_cnt      <= '0;
        bus.chk_cnt      <= '0;
        bus.illegal_seen <= 1'b0;
        bus.fail         <= 1'b0;
      end else begin
        bus.mismatch <= 1'b0;
        if (bus.en && bus.s && bus.r)
          bus.illegal_seen <= 1'b1;
        unique case (state)
          IDLE: begin
            if (bus.en)
              state <= RUN;
          end
          RUN: begin
            if (chk) begin
              bus.chk_cnt  <= chk_nxt;
              bus.err_cnt  <= err_nxt;
              bus.mismatch <= bad;
              bus.fail     <= fail_nxt;
            end
            if (!bus.en)
              state <= IDLE;
            else if (fail_nxt && (STOP_ON_FAIL != 0))
              state <= HALT;
          end
          HALT: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_srff_resp_checker.sv
// Directed bench: a behavioural SR flop with fault injection feeds
// three checker instances with different parameter sets.
module tb_srff_resp_checker;

  logic clk;
  logic rst;
  logic en, clr, s, r;
  logic stuck, qeq;
  logic fq;
  logic q, qbar;
  int   checks;
  int   errors;

  srff_resp_checker_if #(.CNT_W(8)) bus0 ();
  srff_resp_checker_if #(.CNT_W(8)) bus1 ();
  srff_resp_checker_if #(.CNT_W(8)) bus2 ();

  srff_resp_checker #(
    .CNT_W(8), .FAIL_THRESH(1),
    .STOP_ON_FAIL(0), .ILLEGAL_POL(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  srff_resp_checker #(
    .CNT_W(8), .FAIL_THRESH(3),
    .STOP_ON_FAIL(1), .ILLEGAL_POL(0)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  srff_resp_checker #(
    .CNT_W(8), .FAIL_THRESH(1),
    .STOP_ON_FAIL(0), .ILLEGAL_POL(1)
  ) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  assign bus0.en = en;  assign bus0.clr = clr;
  assign bus0.s  = s;   assign bus0.r   = r;
  assign bus0.q  = q;   assign bus0.qbar = qbar;
  assign bus1.en = en;  assign bus1.clr = clr;
  assign bus1.s  = s;   assign bus1.r   = r;
  assign bus1.q  = q;   assign bus1.qbar = qbar;
  assign bus2.en = en;  assign bus2.clr = clr;
  assign bus2.s  = s;   assign bus2.r   = r;
  assign bus2.q  = q;   assign bus2.qbar = qbar;

  // flop under check, set-dominant, with stuck-at-0 and qbar faults
  always @(posedge clk or posedge rst) begin
    if (rst) fq <= 1'b0;
    else if (s) fq <= 1'b1;
    else if (r) fq <= 1'b0;
  end
  assign q    = stuck ? 1'b0 : fq;
  assign qbar = qeq ? q : ~q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sr(input logic [1:0] v);
    {s, r} = v;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      {s, r}  = 2'($urandom_range(0, 3));
      stuck   = 1'($urandom_range(0, 1));
      qeq     = 1'($urandom_range(0, 1));
      en      = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    if (bus0.model_q !== 1'b0) begin
      errors++;
      $display("FAIL rst_mq: got %0b exp 0", bus0.model_q);
    end
    checks++;
    if (bus0.model_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mv: got %0b exp 1", bus0.model_valid);
    end
    checks++;
    if (bus0.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL rst_mm: got %0b exp 0", bus0.mismatch);
    end
    checks++;
    if ({bus0.err_cnt, bus0.chk_cnt} !== 16'd0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d/%0d exp 0/0",
               bus0.err_cnt, bus0.chk_cnt);
    end
    checks++;
    if ({bus0.illegal_seen, bus0.fail} !== 2'b00) begin
      errors++;
      $display("FAIL rst_flags: got %0b%0b exp 00",
               bus0.illegal_seen, bus0.fail);
    end
    sr(2'b00); stuck = 0; qeq = 0; en = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_good();
    logic [1:0] vec [5];
    vec = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b10};
    en = 1; sr(2'b00);
    tick();
    checks++;
    if (bus0.chk_cnt !== 8'd0) begin
      errors++;
      $display("FAIL good_warm: got %0d exp 0", bus0.chk_cnt);
    end
    foreach (vec[i]) begin
      sr(vec[i]);
      tick();
    end
    checks++;
    if (bus0.chk_cnt !== 8'd5) begin
      errors++;
      $display("FAIL good_chk: got %0d exp 5", bus0.chk_cnt);
    end
    checks++;
    if (bus0.err_cnt !== 8'd0 || bus0.fail !== 1'b0) begin
      errors++;
      $display("FAIL good_err: got %0d/%0b exp 0/0",
               bus0.err_cnt, bus0.fail);
    end
    checks++;
    if (bus0.model_q !== 1'b1) begin
      errors++;
      $display("FAIL good_mq: got %0b exp 1", bus0.model_q);
    end
    sr(2'b00); en = 0;
    tick();
  endtask

  task automatic test_stuck();
    sr(2'b01);
    tick();
    en = 1; sr(2'b00);
    tick();
    stuck = 1; sr(2'b10);
    tick();
    checks++;
    if (bus0.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL stuck_pre: got %0b exp 0", bus0.mismatch);
    end
    sr(2'b00);
    tick();
    checks++;
    if (bus0.mismatch !== 1'b1) begin
      errors++;
      $display("FAIL stuck_mm: got %0b exp 1", bus0.mismatch);
    end
    checks++;
    if (bus0.err_cnt !== 8'd1 || bus0.fail !== 1'b1) begin
      errors++;
      $display("FAIL stuck_err: got %0d/%0b exp 1/1",
               bus0.err_cnt, bus0.fail);
    end
    stuck = 0;
    tick();
    checks++;
    if (bus0.mismatch !== 1'b0 || bus0.fail !== 1'b1) begin
      errors++;
      $display("FAIL stuck_post: got %0b/%0b exp 0/1",
               bus0.mismatch, bus0.fail);
    end
    checks++;
    if (bus0.chk_cnt !== 8'd8) begin
      errors++;
      $display("FAIL stuck_chk: got %0d exp 8", bus0.chk_cnt);
    end
  endtask

  task automatic test_saturate();
    qeq = 1;
    tick();
    checks++;
    if (bus0.err_cnt !== 8'd2 || bus0.mismatch !== 1'b1) begin
      errors++;
      $display("FAIL sat_step: got %0d/%0b exp 2/1",
               bus0.err_cnt, bus0.mismatch);
    end
    for (int i = 0; i < 259; i++) tick();
    checks++;
    if (bus0.err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_err: got %0d exp 255", bus0.err_cnt);
    end
    checks++;
    if (bus0.chk_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_chk: got %0d exp 255", bus0.chk_cnt);
    end
    checks++;
    if (bus0.mismatch !== 1'b1) begin
      errors++;
      $display("FAIL sat_mm: got %0b exp 1", bus0.mismatch);
    end
    qeq = 0; clr = 1;
    tick();
    clr = 0;
    checks++;
    if ({bus0.err_cnt, bus0.chk_cnt} !== 16'd0
        || bus0.fail !== 1'b0) begin
      errors++;
      $display("FAIL clr_cnt: got %0d/%0d/%0b exp 0/0/0",
               bus0.err_cnt, bus0.chk_cnt, bus0.fail);
    end
    tick();
    checks++;
    if (bus0.chk_cnt !== 8'd0) begin
      errors++;
      $display("FAIL clr_idle: got %0d exp 0", bus0.chk_cnt);
    end
  endtask

  task automatic test_illegal();
    sr(2'b01);
    tick();
    sr(2'b11);
    tick();
    checks++;
    if (bus0.illegal_seen !== 1'b1) begin
      errors++;
      $display("FAIL ill_seen: got %0b exp 1", bus0.illegal_seen);
    end
    checks++;
    if (bus0.model_valid !== 1'b0 || bus0.model_q !== 1'b0) begin
      errors++;
      $display("FAIL ill_model: got %0b/%0b exp 0/0",
               bus0.model_valid, bus0.model_q);
    end
    checks++;
    if (bus2.model_q !== 1'b1 || bus2.model_valid !== 1'b1) begin
      errors++;
      $display("FAIL ill_setdom: got %0b/%0b exp 1/1",
               bus2.model_q, bus2.model_valid);
    end
    sr(2'b00);
    tick();
    checks++;
    if (bus0.err_cnt !== 8'd0 || bus0.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL ill_skip: got %0d/%0b exp 0/0",
               bus0.err_cnt, bus0.mismatch);
    end
    sr(2'b01);
    tick();
    checks++;
    if (bus0.model_valid !== 1'b1 || bus0.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ill_revalid: got %0b/%0d exp 1/0",
               bus0.model_valid, bus0.err_cnt);
    end
    sr(2'b00);
    tick();
    checks++;
    if (bus0.chk_cnt !== 8'd5 || bus0.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL ill_chk: got %0d/%0d exp 5/0",
               bus0.chk_cnt, bus0.err_cnt);
    end
  endtask

  task automatic test_halt();
    rst = 1; sr(2'b00); stuck = 0; qeq = 0;
    #2;
    checks++;
    if (bus1.err_cnt !== 8'd0 || bus1.fail !== 1'b0) begin
      errors++;
      $display("FAIL halt_rst0: got %0d/%0b exp 0/0",
               bus1.err_cnt, bus1.fail);
    end
    tick();
    rst = 0;
    tick();
    stuck = 1; sr(2'b10);
    tick();
    sr(2'b00);
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus1.err_cnt !== 8'd3 || bus1.fail !== 1'b1
        || bus1.mismatch !== 1'b1) begin
      errors++;
      $display("FAIL halt_3rd: got %0d/%0b/%0b exp 3/1/1",
               bus1.err_cnt, bus1.fail, bus1.mismatch);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus1.err_cnt !== 8'd3 || bus1.chk_cnt !== 8'd4
        || bus1.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL halt_hold: got %0d/%0d/%0b exp 3/4/0",
               bus1.err_cnt, bus1.chk_cnt, bus1.mismatch);
    end
    sr(2'b01);
    tick();
    checks++;
    if (bus1.model_q !== 1'b0) begin
      errors++;
      $display("FAIL halt_track: got %0b exp 0", bus1.model_q);
    end
    checks++;
    if (bus0.mismatch !== 1'b1) begin
      errors++;
      $display("FAIL halt_inflt: got %0b exp 1", bus0.mismatch);
    end
    sr(2'b00); rst = 1;
    #2;
    checks++;
    if ({bus1.err_cnt, bus1.chk_cnt} !== 16'd0
        || bus1.fail !== 1'b0) begin
      errors++;
      $display("FAIL halt_rst: got %0d/%0d/%0b exp 0/0/0",
               bus1.err_cnt, bus1.chk_cnt, bus1.fail);
    end
    checks++;
    if (bus0.mismatch !== 1'b0) begin
      errors++;
      $display("FAIL halt_drop: got %0b exp 0", bus0.mismatch);
    end
    tick();
    rst = 0; stuck = 0;
    tick();
    checks++;
    if (bus1.chk_cnt !== 8'd0) begin
      errors++;
      $display("FAIL halt_idle: got %0d exp 0", bus1.chk_cnt);
    end
    tick();
    checks++;
    if (bus1.chk_cnt !== 8'd1 || bus1.err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL halt_rerun: got %0d/%0d exp 1/0",
               bus1.chk_cnt, bus1.err_cnt);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1; en = 0; clr = 0;
    s = 0; r = 0; stuck = 0; qeq = 0;
    test_reset();
    test_good();
    test_stuck();
    test_saturate();
    test_illegal();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
